// File: rtl/lc3b_types.sv
// Shared LC-3b type package: arbiter state/master encodings and the L1-to-L2 line port geometry.
package lc3b_types;

    localparam int LINE_W = 128;
    localparam int ADR_W  = 12;
    localparam int SEL_W  = LINE_W / 8;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        MASTER_I = 1'b0,
        MASTER_D = 1'b1
    } arb_master_t;

endpackage

// File: rtl/l1_wb_arbiter_mux.sv
// Combinational output steering for the L1 Wishbone arbiter; driven purely by the registered grant state.
module l1_wb_arbiter_mux
    import lc3b_types::*;
#(
    parameter int ADR_W  = lc3b_types::ADR_W,
    parameter int LINE_W = lc3b_types::LINE_W,
    parameter int SEL_W  = lc3b_types::SEL_W
) (
    input  arb_state_t        state,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [ADR_W-1:0]  i_adr,
    input  logic [LINE_W-1:0] i_dat_w,
    output logic [LINE_W-1:0] i_dat_r,
    output logic              i_ack,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADR_W-1:0]  d_adr,
    input  logic [LINE_W-1:0] d_dat_w,
    output logic [LINE_W-1:0] d_dat_r,
    output logic              d_ack,
    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [SEL_W-1:0]  l2_sel,
    output logic [ADR_W-1:0]  l2_adr,
    output logic [LINE_W-1:0] l2_dat_w,
    input  logic [LINE_W-1:0] l2_dat_r,
    input  logic              l2_ack
);

    // The non-granted master sees silence; IDLE drives nothing toward L2.
    always_comb begin
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_sel   = '0;
        l2_adr   = '0;
        l2_dat_w = '0;
        i_ack    = 1'b0;
        i_dat_r  = '0;
        d_ack    = 1'b0;
        d_dat_r  = '0;
        case (state)
            GRANT_I: begin
                l2_cyc   = i_cyc;
                l2_stb   = i_stb;
                l2_we    = i_we;
                l2_sel   = i_sel;
                l2_adr   = i_adr;
                l2_dat_w = i_dat_w;
                i_ack    = l2_ack;
                i_dat_r  = l2_dat_r;
            end
            GRANT_D: begin
                l2_cyc   = d_cyc;
                l2_stb   = d_stb;
                l2_we    = d_we;
                l2_sel   = d_sel;
                l2_adr   = d_adr;
                l2_dat_w = d_dat_w;
                d_ack    = l2_ack;
                d_dat_r  = l2_dat_r;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/l1_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the L2 line port between icache and dcache.
// Optional per-master wait counters are enabled with L1_ARB_PERF_COUNTERS_EN.
module l1_wb_arbiter
    import lc3b_types::*;
#(
    parameter int ADR_W  = lc3b_types::ADR_W,
    parameter int LINE_W = lc3b_types::LINE_W,
    parameter int SEL_W  = lc3b_types::SEL_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [ADR_W-1:0]  i_adr,
    input  logic [LINE_W-1:0] i_dat_w,
    output logic [LINE_W-1:0] i_dat_r,
    output logic              i_ack,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADR_W-1:0]  d_adr,
    input  logic [LINE_W-1:0] d_dat_w,
    output logic [LINE_W-1:0] d_dat_r,
    output logic              d_ack,
    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [SEL_W-1:0]  l2_sel,
    output logic [ADR_W-1:0]  l2_adr,
    output logic [LINE_W-1:0] l2_dat_w,
    input  logic [LINE_W-1:0] l2_dat_r,
    input  logic              l2_ack
`ifdef L1_ARB_PERF_COUNTERS_EN
    ,
    output lc3b_word          i_wait_counter,
    output lc3b_word          d_wait_counter
`endif
);

    arb_state_t  state_q, state_d;
    arb_master_t last_grant_q, last_grant_d;
    logic        req_i, req_d;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

    // Ties go to whoever was not served last; a dropped cyc abandons the grant without updating fairness.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = (last_grant_q == MASTER_I) ? GRANT_D : GRANT_I;
                end else if (req_d) begin
                    state_d = GRANT_D;
                end else if (req_i) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I: begin
                if (l2_ack) begin
                    state_d      = IDLE;
                    last_grant_d = MASTER_I;
                end else if (!i_cyc) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                if (l2_ack) begin
                    state_d      = IDLE;
                    last_grant_d = MASTER_D;
                end else if (!d_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= MASTER_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef L1_ARB_PERF_COUNTERS_EN
    lc3b_word i_wait_q, i_wait_d, d_wait_q, d_wait_d;

    // A master is waiting whenever it requests but does not own the port, including the IDLE cycle before its grant.
    always_comb begin
        i_wait_d = i_wait_q;
        d_wait_d = d_wait_q;
        if (req_i && (state_q != GRANT_I) && (i_wait_q != 16'hFFFF)) begin
            i_wait_d = i_wait_q + 16'd1;
        end
        if (req_d && (state_q != GRANT_D) && (d_wait_q != 16'hFFFF)) begin
            d_wait_d = d_wait_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_wait_q <= '0;
            d_wait_q <= '0;
        end else begin
            i_wait_q <= i_wait_d;
            d_wait_q <= d_wait_d;
        end
    end

    assign i_wait_counter = i_wait_q;
    assign d_wait_counter = d_wait_q;
`endif

    l1_wb_arbiter_mux #(
        .ADR_W  (ADR_W),
        .LINE_W (LINE_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .state    (state_q),
        .i_cyc    (i_cyc),
        .i_stb    (i_stb),
        .i_we     (i_we),
        .i_sel    (i_sel),
        .i_adr    (i_adr),
        .i_dat_w  (i_dat_w),
        .i_dat_r  (i_dat_r),
        .i_ack    (i_ack),
        .d_cyc    (d_cyc),
        .d_stb    (d_stb),
        .d_we     (d_we),
        .d_sel    (d_sel),
        .d_adr    (d_adr),
        .d_dat_w  (d_dat_w),
        .d_dat_r  (d_dat_r),
        .d_ack    (d_ack),
        .l2_cyc   (l2_cyc),
        .l2_stb   (l2_stb),
        .l2_we    (l2_we),
        .l2_sel   (l2_sel),
        .l2_adr   (l2_adr),
        .l2_dat_w (l2_dat_w),
        .l2_dat_r (l2_dat_r),
        .l2_ack   (l2_ack)
    );

endmodule

// File: tb/tb_l1_wb_arbiter.sv
// Self-checking bench for l1_wb_arbiter: directed scenarios plus randomized traffic against a port-ownership model.
module tb_l1_wb_arbiter;
    import lc3b_types::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         i_cyc, i_stb, i_we, i_ack;
    logic [15:0]  i_sel;
    logic [11:0]  i_adr;
    logic [127:0] i_dat_w, i_dat_r;
    logic         d_cyc, d_stb, d_we, d_ack;
    logic [15:0]  d_sel;
    logic [11:0]  d_adr;
    logic [127:0] d_dat_w, d_dat_r;
    logic         l2_cyc, l2_stb, l2_we, l2_ack;
    logic [15:0]  l2_sel;
    logic [11:0]  l2_adr;
    logic [127:0] l2_dat_w, l2_dat_r;
`ifdef L1_ARB_PERF_COUNTERS_EN
    lc3b_word     i_wait_counter, d_wait_counter;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model: who owns the L2 port (0 none, 1 icache, 2 dcache) and who was served last.
    int owner      = 0;
    int last_grant = 1;
    int exp_iw     = 0;
    int exp_dw     = 0;
    bit i_done     = 1'b0;
    bit d_done     = 1'b0;

    always #5 CLK = ~CLK;

    l1_wb_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .i_cyc    (i_cyc),
        .i_stb    (i_stb),
        .i_we     (i_we),
        .i_sel    (i_sel),
        .i_adr    (i_adr),
        .i_dat_w  (i_dat_w),
        .i_dat_r  (i_dat_r),
        .i_ack    (i_ack),
        .d_cyc    (d_cyc),
        .d_stb    (d_stb),
        .d_we     (d_we),
        .d_sel    (d_sel),
        .d_adr    (d_adr),
        .d_dat_w  (d_dat_w),
        .d_dat_r  (d_dat_r),
        .d_ack    (d_ack),
        .l2_cyc   (l2_cyc),
        .l2_stb   (l2_stb),
        .l2_we    (l2_we),
        .l2_sel   (l2_sel),
        .l2_adr   (l2_adr),
        .l2_dat_w (l2_dat_w),
        .l2_dat_r (l2_dat_r),
        .l2_ack   (l2_ack)
`ifdef L1_ARB_PERF_COUNTERS_EN
        ,
        .i_wait_counter (i_wait_counter),
        .d_wait_counter (d_wait_counter)
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from who owns the port this cycle.
    task automatic checkAll();
        bit gi;
        bit gd;
        gi = (owner == 1);
        gd = (owner == 2);
        checkOutput("l2_cyc",   l2_cyc,   gi ? i_cyc   : gd ? d_cyc   : 1'b0);
        checkOutput("l2_stb",   l2_stb,   gi ? i_stb   : gd ? d_stb   : 1'b0);
        checkOutput("l2_we",    l2_we,    gi ? i_we    : gd ? d_we    : 1'b0);
        checkOutput("l2_sel",   l2_sel,   gi ? i_sel   : gd ? d_sel   : 16'h0);
        checkOutput("l2_adr",   l2_adr,   gi ? i_adr   : gd ? d_adr   : 12'h0);
        checkOutput("l2_dat_w", l2_dat_w, gi ? i_dat_w : gd ? d_dat_w : 128'h0);
        checkOutput("i_ack",    i_ack,    gi ? l2_ack : 1'b0);
        checkOutput("i_dat_r",  i_dat_r,  gi ? l2_dat_r : 128'h0);
        checkOutput("d_ack",    d_ack,    gd ? l2_ack : 1'b0);
        checkOutput("d_dat_r",  d_dat_r,  gd ? l2_dat_r : 128'h0);
`ifdef L1_ARB_PERF_COUNTERS_EN
        checkOutput("i_wait_counter", i_wait_counter, 128'(exp_iw));
        checkOutput("d_wait_counter", d_wait_counter, 128'(exp_dw));
`endif
    endtask

    // One clock cycle: check current outputs, advance the model across the edge, return at the next negedge.
    task automatic applyStimulus();
        bit ri;
        bit rd;
        int nxt;
        int nl;
        #1;
        checkAll();
        ri     = i_cyc && i_stb;
        rd     = d_cyc && d_stb;
        i_done = (owner == 1) && l2_ack;
        d_done = (owner == 2) && l2_ack;
        nxt    = owner;
        nl     = last_grant;
        if (RST) begin
            nxt    = 0;
            nl     = 1;
            exp_iw = 0;
            exp_dw = 0;
        end else begin
            if (ri && owner != 1 && exp_iw < 65535) exp_iw++;
            if (rd && owner != 2 && exp_dw < 65535) exp_dw++;
            if (owner == 0) begin
                if (ri && rd) nxt = 3 - last_grant;
                else if (rd) nxt = 2;
                else if (ri) nxt = 1;
            end else if (l2_ack) begin
                nl  = owner;
                nxt = 0;
            end else if (!((owner == 1) ? i_cyc : d_cyc)) begin
                nxt = 0;
            end
        end
        @(posedge CLK);
        owner      = nxt;
        last_grant = nl;
        @(negedge CLK);
    endtask

    task automatic idleInputs();
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_sel = '0; i_adr = '0; i_dat_w = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_sel = '0; d_adr = '0; d_dat_w = '0;
        l2_ack = 1'b0; l2_dat_r = '0;
    endtask

    task automatic doReset();
        idleInputs();
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
    endtask

    task automatic randomDrive();
        if (i_cyc && (i_done || $urandom_range(0, 31) == 0)) begin
            i_cyc = 1'b0; i_stb = 1'b0;
        end else if (!i_cyc && $urandom_range(0, 3) == 0) begin
            i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'($urandom_range(0, 1));
            i_sel = 16'($urandom); i_adr = 12'($urandom);
            i_dat_w = {$urandom, $urandom, $urandom, $urandom};
        end
        if (d_cyc && (d_done || $urandom_range(0, 31) == 0)) begin
            d_cyc = 1'b0; d_stb = 1'b0;
        end else if (!d_cyc && $urandom_range(0, 3) == 0) begin
            d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_sel = 16'($urandom); d_adr = 12'($urandom);
            d_dat_w = {$urandom, $urandom, $urandom, $urandom};
        end
        l2_ack   = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        l2_dat_r = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int lat;
        int order_idx;
        idleInputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        $display("[TB] reset state");
        #1 checkOutput("reset_l2_cyc", l2_cyc, 1'b0);
        applyStimulus();

        $display("[TB] single icache read");
        i_cyc = 1'b1; i_stb = 1'b1; i_sel = 16'hFFFF; i_adr = 12'h0A3;
        applyStimulus();
        #1 checkOutput("read_adr_c1", l2_adr, 12'h0A3);
        applyStimulus();
        applyStimulus();
        l2_ack = 1'b1; l2_dat_r = 128'hDEAD_BEEF_0000_1111_2222_3333_DEAD_BEEF;
        #1 checkOutput("read_i_ack", i_ack, 1'b1);
        checkOutput("read_i_dat_r", i_dat_r, 128'hDEAD_BEEF_0000_1111_2222_3333_DEAD_BEEF);
        checkOutput("read_d_ack", d_ack, 1'b0);
        checkOutput("read_adr_c3", l2_adr, 12'h0A3);
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] tie after reset and continuous contention");
        doReset();
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h111;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h222;
        lat = 0;
        order_idx = 0;
        for (int c = 0; c < 19; c++) begin
            l2_ack = (owner != 0) && (lat == 1);
            if (owner != 0 && lat == 0) begin
                #1 checkOutput("grant_order", l2_adr, (order_idx % 2 == 0) ? 12'h222 : 12'h111);
                order_idx++;
            end
            lat = (owner != 0) ? lat + 1 : 0;
            applyStimulus();
        end
        idleInputs();
        applyStimulus();

        $display("[TB] dcache write");
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 16'hFFFF; d_adr = 12'h3F0;
        d_dat_w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        applyStimulus();
        #1 checkOutput("write_l2_we", l2_we, 1'b1);
        checkOutput("write_l2_dat_w", l2_dat_w, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        applyStimulus();
        l2_ack = 1'b1;
        #1 checkOutput("write_i_ack", i_ack, 1'b0);
        checkOutput("write_d_ack", d_ack, 1'b1);
        checkOutput("write_l2_sel", l2_sel, 16'hFFFF);
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] abort keeps last grant");
        doReset();
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h03C;
        applyStimulus();
        applyStimulus();
        d_cyc = 1'b0; d_stb = 1'b0;
        applyStimulus();
        #1 checkOutput("abort_l2_cyc", l2_cyc, 1'b0);
        applyStimulus();
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h0AA;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h0DD;
        applyStimulus();
        #1 checkOutput("abort_tie_to_d", l2_adr, 12'h0DD);
        applyStimulus();
        l2_ack = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] reset mid icache grant");
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h555;
        applyStimulus();
        applyStimulus();
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        l2_ack = 1'b1;
        #1 checkOutput("rst_mid_l2_cyc", l2_cyc, 1'b0);
        checkOutput("rst_mid_i_ack", i_ack, 1'b0);
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] randomized traffic");
        doReset();
        repeat (600) begin
            randomDrive();
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
